// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style bus machine: opcodes, control-word layout and
// the microcode LAST marker.
package sap_pkg;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJc  = 4'h7,
    OpJz  = 4'h8,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  // Control-word bits are held active-high here; the top level inverts the _n ones.
  localparam int unsigned CwCo   = 0;
  localparam int unsigned CwMi   = 1;
  localparam int unsigned CwRo   = 2;
  localparam int unsigned CwIi   = 3;
  localparam int unsigned CwCe   = 4;
  localparam int unsigned CwIo   = 5;
  localparam int unsigned CwAi   = 6;
  localparam int unsigned CwBi   = 7;
  localparam int unsigned CwEo   = 8;
  localparam int unsigned CwFi   = 9;
  localparam int unsigned CwSu   = 10;
  localparam int unsigned CwRi   = 11;
  localparam int unsigned CwAo   = 12;
  localparam int unsigned CwJ    = 13;
  localparam int unsigned CwOi   = 14;
  localparam int unsigned CwHlt  = 15;
  localparam int unsigned CwFclr = 16;
  localparam int unsigned CwWidth = 17;

  // A microcode entry is the control word with the LAST marker appended on top.
  localparam int unsigned LAST    = CwWidth;
  localparam int unsigned UwWidth = CwWidth + 1;

  localparam logic [CwWidth-1:0] CwIdle = '0;

  function automatic logic [CwWidth-1:0] sig(input int unsigned idx);
    logic [CwWidth-1:0] w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  // True for opcodes that run at least one execute step.
  function automatic logic has_execute(input logic [3:0] op);
    return op inside {OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp, OpJc, OpJz, OpOut, OpHlt};
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode lookup: (opcode, step, flags) -> control word plus LAST marker.
module microcode_rom
  import sap_pkg::*;
(
  input  logic [3:0]         opcode_i,
  input  logic [2:0]         step_i,
  input  logic [1:0]         flags_i,
  output logic [UwWidth-1:0] uword_o
);

  logic [CwWidth-1:0] cw;
  logic               last;

  always_comb begin
    cw   = CwIdle;
    last = 1'b0;
    if (step_i == 3'd0) begin
      cw = sig(CwCo) | sig(CwMi);
    end else if (step_i == 3'd1) begin
      cw   = sig(CwRo) | sig(CwIi) | sig(CwCe);
      last = !has_execute(opcode_i);
    end else begin
      // Any step not listed below is past the instruction's end.
      last = 1'b1;
      case (opcode_i)
        OpLda: begin
          if (step_i == 3'd2) begin
            cw   = sig(CwIo) | sig(CwMi);
            last = 1'b0;
          end else if (step_i == 3'd3) begin
            cw = sig(CwRo) | sig(CwAi);
          end
        end
        OpAdd, OpSub: begin
          if (step_i == 3'd2) begin
            cw   = sig(CwIo) | sig(CwMi);
            last = 1'b0;
          end else if (step_i == 3'd3) begin
            cw   = sig(CwRo) | sig(CwBi) | ((opcode_i == OpSub) ? sig(CwSu) : CwIdle);
            last = 1'b0;
          end else if (step_i == 3'd4) begin
            cw = sig(CwEo) | sig(CwAi) | sig(CwFi) |
                 ((opcode_i == OpSub) ? sig(CwSu) : CwIdle);
          end
        end
        OpSta: begin
          if (step_i == 3'd2) begin
            cw   = sig(CwIo) | sig(CwMi);
            last = 1'b0;
          end else if (step_i == 3'd3) begin
            cw = sig(CwAo) | sig(CwRi);
          end
        end
        OpLdi: if (step_i == 3'd2) cw = sig(CwIo) | sig(CwAi);
        OpJmp: if (step_i == 3'd2) cw = sig(CwIo) | sig(CwJ);
        OpJc:  if (step_i == 3'd2 && flags_i[0]) cw = sig(CwIo) | sig(CwJ);
        OpJz:  if (step_i == 3'd2 && flags_i[1]) cw = sig(CwIo) | sig(CwJ);
        OpOut: if (step_i == 3'd2) cw = sig(CwAo) | sig(CwOi);
        OpHlt: begin
          if (step_i == 3'd2) begin
            cw   = sig(CwHlt);
            last = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign uword_o = {last, cw};

endmodule

// File: rtl/control_sequencer.sv
// Step counter and control-word driver for the bus machine; microcode lives in microcode_rom.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned STEPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [1:0] flags,
  output logic       hlt,
  output logic       mi_n,
  output logic       ri_n,
  output logic       ro_n,
  output logic       ii_n,
  output logic       io_n,
  output logic       ai_n,
  output logic       ao_n,
  output logic       eo_n,
  output logic       su,
  output logic       bi_n,
  output logic       oi_n,
  output logic       ce,
  output logic       co_n,
  output logic       j_n,
  output logic       fi_n,
  output logic       fclr_n,
  output logic [2:0] step
);

  logic [2:0]         step_q, step_d;
  logic [UwWidth-1:0] uword;
  logic [CwWidth-1:0] cw;

  microcode_rom u_rom (
    .opcode_i (opcode),
    .step_i   (step_q),
    .flags_i  (flags),
    .uword_o  (uword)
  );

  always_comb begin
    step_d = step_q + 3'd1;
    if (uword[LAST] || step_q == 3'(STEPS - 1)) step_d = 3'd0;
    // HLT parks the counter until reset.
    if (uword[CwHlt]) step_d = step_q;
  end

  always_ff @(posedge clk) begin
    if (reset) step_q <= 3'd0;
    else       step_q <= step_d;
  end

  // Reset suppresses every load immediately and clears the ALU flags.
  assign cw = reset ? sig(CwFclr) : uword[CwWidth-1:0];

  assign hlt    = cw[CwHlt];
  assign mi_n   = ~cw[CwMi];
  assign ri_n   = ~cw[CwRi];
  assign ro_n   = ~cw[CwRo];
  assign ii_n   = ~cw[CwIi];
  assign io_n   = ~cw[CwIo];
  assign ai_n   = ~cw[CwAi];
  assign ao_n   = ~cw[CwAo];
  assign eo_n   = ~cw[CwEo];
  assign su     = cw[CwSu];
  assign bi_n   = ~cw[CwBi];
  assign oi_n   = ~cw[CwOi];
  assign ce     = cw[CwCe];
  assign co_n   = ~cw[CwCo];
  assign j_n    = ~cw[CwJ];
  assign fi_n   = ~cw[CwFi];
  assign fclr_n = ~cw[CwFclr];
  assign step   = step_q;

endmodule
